// File: rtl/lane_spawn_scheduler_pkg.sv
// frog_pkg: shared state, lane and speed types plus default sizing for the spawn scheduler
package frog_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, REQ} spawn_state_t;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_MIN_GAP_FRAMES = 8;
  localparam int DEF_CD_W = 5;
  typedef logic [$clog2(DEF_NUM_LANES)-1:0] lane_t;
  typedef logic [1:0] speed_t;
endpackage

// File: rtl/lane_spawn_scheduler_if.sv
// lane_spawn_scheduler_if: spawn request handshake between scheduler and obstacle pool
interface lane_spawn_scheduler_if
  import frog_pkg::*;
#(
  parameter int LANE_W = 2
);
  logic spawn_req;
  logic [LANE_W-1:0] spawn_lane;
  logic spawn_dir;
  speed_t spawn_speed;
  logic spawn_ack;
  modport master (output spawn_req, spawn_lane, spawn_dir, spawn_speed, input spawn_ack);
  modport slave (input spawn_req, spawn_lane, spawn_dir, spawn_speed, output spawn_ack);
endinterface

// File: rtl/lane_spawn_scheduler_lane_cooldown_counter.sv
// lane_cooldown_counter: saturating frame cooldown for one lane, load beats tick
module lane_cooldown_counter #(
  parameter int CD_W = 5
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            tick,
  input  logic            load,
  input  logic [CD_W-1:0] load_val,
  output logic            zero
);
  logic [CD_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (tick && cnt_q != '0) ? cnt_q - CD_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/lane_spawn_scheduler.sv
// lane_spawn_scheduler: per-frame obstacle spawn decision with per-lane minimum spawn gap
module lane_spawn_scheduler
  import frog_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int MIN_GAP_FRAMES = DEF_MIN_GAP_FRAMES,
  parameter int CD_W = DEF_CD_W,
  localparam int LANE_W = $clog2(NUM_LANES)
) (
  input logic clk,
  input logic resetN,
  input logic startOfFrame,
  input logic enable,
  input logic [3:0] random,
  lane_spawn_scheduler_if.master spawn
);
  spawn_state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [NUM_LANES-1:0] snap_q, snap_d, zero, load;
  logic req_q, req_d, dir_q, dir_d, tick;
  logic [LANE_W-1:0] lane_q, lane_d, rnd_lane;
  speed_t speed_q, speed_d, rnd_pr;
  logic [CD_W-1:0] load_val;
  if (NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
    $error("NUM_LANES must be 2 or 4");
  end
  if (MIN_GAP_FRAMES < 1 || MIN_GAP_FRAMES > 28 || MIN_GAP_FRAMES + 3 >= 2 ** CD_W) begin : g_bad_gap
    $error("MIN_GAP_FRAMES out of range or MIN_GAP_FRAMES+3 does not fit in CD_W bits");
  end
  assign tick = startOfFrame && enable;
  assign rnd_lane = rnd_q[LANE_W-1:0];
  assign rnd_pr = rnd_q[3:2];
  assign load_val = CD_W'(MIN_GAP_FRAMES) + CD_W'(speed_q);
  // lane gap is judged on the cooldown seen at the frame pulse, before that frame's decrement
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign load[i] = state_q == REQ && enable && spawn.spawn_ack && lane_q == LANE_W'(i);
    lane_cooldown_counter #(.CD_W(CD_W)) u_cd (
      .clk(clk),
      .resetN(resetN),
      .tick(tick),
      .load(load[i]),
      .load_val(load_val),
      .zero(zero[i])
    );
  end
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    snap_d = snap_q;
    req_d = req_q;
    lane_d = lane_q;
    dir_d = dir_q;
    speed_d = speed_q;
    case (state_q)
      IDLE: if (tick) begin
        rnd_d = random;
        snap_d = zero;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = IDLE;
        if (rnd_pr != 2'd0 && snap_q[rnd_lane]) begin
          state_d = REQ;
          req_d = 1'b1;
          lane_d = rnd_lane;
          dir_d = rnd_lane[0];
          speed_d = rnd_pr;
        end
      end
      REQ: if (!enable || spawn.spawn_ack) begin
        state_d = IDLE;
        req_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      rnd_q <= '0;
      snap_q <= '0;
      req_q <= 1'b0;
      lane_q <= '0;
      dir_q <= 1'b0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      snap_q <= snap_d;
      req_q <= req_d;
      lane_q <= lane_d;
      dir_q <= dir_d;
      speed_q <= speed_d;
    end
  assign spawn.spawn_req = req_q;
  assign spawn.spawn_lane = lane_q;
  assign spawn.spawn_dir = dir_q;
  assign spawn.spawn_speed = speed_q;
endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// tb_lane_spawn_scheduler: directed frames checked against a frame-level spawn model
module tb_lane_spawn_scheduler;
  localparam int NL = 4;
  localparam int MIN = 8;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic enable = 1'b1;
  logic [3:0] random = 4'h0;
  bit chk_on = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_cd [NL];
  bit m_snap [NL];
  bit m_req, m_eval;
  int m_lane, m_dir, m_speed;
  logic [3:0] m_rnd;
  lane_spawn_scheduler_if #(.LANE_W(2)) sif ();
  lane_spawn_scheduler #(.NUM_LANES(NL), .MIN_GAP_FRAMES(MIN), .CD_W(5)) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .enable(enable),
    .random(random),
    .spawn(sif)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // frame-level model: a frame is accepted only when nothing is being judged or requested
  task automatic model_step();
    int nc [NL];
    bit n_req, n_eval;
    if (!resetN) begin
      foreach (m_cd[l]) m_cd[l] = 0;
      m_req = 0; m_eval = 0; m_lane = 0; m_dir = 0; m_speed = 0;
      return;
    end
    nc = m_cd;
    if (startOfFrame && enable) foreach (nc[l]) if (nc[l] > 0) nc[l]--;
    n_req = m_req;
    n_eval = 0;
    if (m_eval) begin
      int ln, pr;
      ln = int'(m_rnd) % NL;
      pr = int'(m_rnd) / 4;
      if (pr != 0 && m_snap[ln]) begin
        n_req = 1; m_lane = ln; m_dir = ln % 2; m_speed = pr;
      end
    end else if (m_req) begin
      if (!enable) n_req = 0;
      else if (sif.spawn_ack) begin
        n_req = 0;
        nc[m_lane] = MIN + m_speed;
      end
    end else if (startOfFrame && enable) begin
      n_eval = 1;
      m_rnd = random;
      foreach (m_snap[l]) m_snap[l] = (m_cd[l] == 0);
    end
    m_cd = nc;
    m_req = n_req;
    m_eval = n_eval;
  endtask
  initial forever begin
    @(posedge clk or negedge resetN);
    model_step();
  end
  always @(negedge clk) if (chk_on) begin
    chk("cyc_req", {31'd0, sif.spawn_req}, m_req);
    if (m_req) begin
      chk("cyc_lane", {30'd0, sif.spawn_lane}, m_lane);
      chk("cyc_dir", {31'd0, sif.spawn_dir}, m_dir);
      chk("cyc_speed", {30'd0, sif.spawn_speed}, m_speed);
    end
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic frame(logic [3:0] r);
    random = r;
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
    step(5);
  endtask
  task automatic ack_pulse();
    sif.spawn_ack = 1'b1;
    step(1);
    sif.spawn_ack = 1'b0;
    step(1);
  endtask
  task automatic chk_out(string nm, int req, int lane, int dir, int speed);
    chk({nm, "_req"}, {31'd0, sif.spawn_req}, req);
    chk({nm, "_lane"}, {30'd0, sif.spawn_lane}, lane);
    chk({nm, "_dir"}, {31'd0, sif.spawn_dir}, dir);
    chk({nm, "_speed"}, {30'd0, sif.spawn_speed}, speed);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, found;
    sif.spawn_ack = 1'b0;
    step(2);
    chk_on = 1'b1;
    chk_out("reset", 0, 0, 0, 0);
    resetN = 1'b1;
    step(1);
    frame(4'b0010);
    chk("t2_no_spawn", {31'd0, sif.spawn_req}, 0);
    random = 4'b0110;
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
    n = 1;
    while (sif.spawn_req !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("t1_latency", n, 2);
    chk_out("t1", 1, 2, 0, 1);
    step(2);
    ack_pulse();
    chk("t1_req_dropped", {31'd0, sif.spawn_req}, 0);
    found = 0;
    for (int k = 1; k <= 15 && found == 0; k++) begin
      frame(4'b0110);
      if (sif.spawn_req) found = k;
    end
    chk("t3_reissue_frame", found, 10);
    ack_pulse();
    frame(4'b1111);
    chk_out("t4_first", 1, 3, 1, 3);
    frame(4'h0);
    chk_out("t4_hold0", 1, 3, 1, 3);
    frame(4'h5);
    chk_out("t4_hold1", 1, 3, 1, 3);
    frame(4'hA);
    chk_out("t4_hold2", 1, 3, 1, 3);
    ack_pulse();
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      frame(4'b1111);
      if (sif.spawn_req) found = k;
    end
    chk("t4_gap_frames", found, 12);
    ack_pulse();
    frame(4'b0101);
    chk_out("t5_req", 1, 1, 1, 1);
    enable = 1'b0;
    step(1);
    chk("t5_abort", {31'd0, sif.spawn_req}, 0);
    frame(4'b0101);
    chk("t5_frozen", {31'd0, sif.spawn_req}, 0);
    sif.spawn_ack = 1'b1;
    step(2);
    sif.spawn_ack = 1'b0;
    enable = 1'b1;
    step(1);
    frame(4'b0101);
    chk_out("t5_reissue", 1, 1, 1, 1);
    ack_pulse();
    frame(4'b0101);
    chk("t5_cooldown", {31'd0, sif.spawn_req}, 0);
    frame(4'b1110);
    chk_out("t6_pre", 1, 2, 0, 3);
    #1;
    resetN = 1'b0;
    #1;
    chk_out("t6_async", 0, 0, 0, 0);
    step(2);
    resetN = 1'b1;
    step(1);
    frame(4'b0101);
    chk_out("t6_after", 1, 1, 1, 1);
    ack_pulse();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
